mix_round_sequencer: RTL and testbench
======================================

# mix_round_sequencer

Multi-cycle controller for the eight-word 32-bit mixing datapath. It seeds the state, runs the eight mixing stages one stage per clock for a programmed number of rounds, and presents the result behind a valid/ready handshake. It sits between a requesting client and the mixing state registers and replaces the single-cycle free-running update with a sequenced, start/done-controlled job.

## Interface
- ROUNDS_W, 4, width of `rounds` and `round_cnt`; a value of 0 on `rounds` means 2^ROUNDS_W rounds.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_valid  in  1  job request.
- start_ready  out  1  high only in IDLE.
- seed  in  32  initial state: o[i] = seed + i, for i = 0..7.
- rounds  in  ROUNDS_W  round count, sampled at start.
- busy  out  1  high in RUN.
- done_valid  out  1  high in DONE.
- done_ready  in  1  result consumed.
- result_sel  in  3  word select.
- result  out  32  combinational o[result_sel].
- round_cnt  out  ROUNDS_W  completed rounds in the current job.
- stage  out  3  stage to be applied on the next RUN edge.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE: start_valid=1 on an edge loads o[i]=seed+i, latches rounds, clears stage and round_cnt, and moves to RUN.
- RUN: each edge applies stage `stage` to o[0..7], then increments stage.
  - When stage 7 completes, stage wraps to 0 and round_cnt increments.
  - When the completed round count reaches the latched target, go to DONE.
- DONE: done_valid=1 and o is frozen. done_valid&&done_ready moves to IDLE. o holds its value in IDLE until the next start.
- start_valid is ignored outside IDLE.
- Each stage evaluates i = 0..7 in order. Each update reads the latest values, so lower indices already hold their new value (blocking semantics), all within one cycle.
- Indices are mod 8. Arithmetic is mod 2^32. Shifts are logical.
  - Stage 0: o[i] += i.
  - Stage 1: o[i] += o[i-1].
  - Stage 2: o[i] = o[i] + o[i+1] - o[i+5].
  - Stage 3: o[i] ^= o[i+3] << 16.
  - Stage 4: o[i] = o[i] - (o[i+2] >> 17) + (o[i+4] >> 12).
  - Stage 5: o[i] = o[i] + o[i-1] - o[i-2].
  - Stage 6: o[i] = o[i]*A[i] + B[i], with A = 2,3,5,7,11,13,17,19 and B = 3,5,7,11,13,17,19,23.
  - Stage 7: o[i] = o[i]*C[i] + D[i], with C = 2,3,3,3,5,13,35,87 and D = 0,1,8,27,64,125,216,343.
- One full round (stages 0..7) equals one clock of the original free-running update.

## Timing
- Reset (async assert, sync release): FSM=IDLE, o[*]=0, stage=0, round_cnt=0, busy=0, done_valid=0, start_ready=1, result=0.
- Start accepted on edge T: busy=1 after T. Stage k of round r is applied on edge T+8r+k+1.
- With R effective rounds, done_valid=1 after edge T+8R. Job latency is 8R cycles; R=2^ROUNDS_W when rounds=0.
- done_ready held high gives IDLE after edge T+8R+1. The next start can be accepted on edge T+8R+2.
- done_ready while not in DONE has no effect.
- rst_n asserted mid-RUN or in DONE clears everything immediately; no done_valid is produced.
- rounds and seed changing during RUN have no effect.

## Configuration
- MIX_SEQ_ABORT_EN defined: adds input `abort` (1 bit).
  - abort=1 on an edge in RUN moves to IDLE. o keeps the partially mixed value, round_cnt and stage hold, and done_valid is never raised.
  - abort in IDLE or DONE is ignored.
  - abort and start on the same IDLE edge: start wins.
- MIX_SEQ_ABORT_EN undefined: no abort port; RUN always completes.

## Test plan
- Reset then seed=0, rounds=1: done_valid rises exactly 8 cycles after acceptance; o[0..7] match the golden C model after one original update from initial values 0..7.
- seed=0, rounds=0: busy held for 128 cycles; result matches 16 model rounds; round_cnt reads 0 after wrap.
- After stage 0 only (observe via stage=1): seed=0 gives o = 0,2,4,6,8,10,12,14.
- done_ready held low 20 cycles: done_valid and result stable; start_valid pulses ignored; release gives IDLE on the next edge.
- rst_n pulsed low at round 3 of rounds=5: all outputs return to reset values immediately; a new job with seed=7 runs cleanly.
- MIX_SEQ_ABORT_EN: abort at cycle 10 of rounds=4 gives IDLE next edge, round_cnt=1, stage=2, no done_valid.

Source files
------------

// File: rtl/mix_round_sequencer.sv
// Sequenced eight-word mixing engine: seeds the state, applies one mixing stage per clock
// for a programmed number of rounds, then presents the result behind a valid/ready handshake.
// Optional feature: define MIX_SEQ_ABORT_EN to add an `abort` input that cancels a running job.
module mix_round_sequencer #(
  parameter int ROUNDS_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [31:0]         seed,
  input  logic [ROUNDS_W-1:0] rounds,
  output logic                busy,
  output logic                done_valid,
  input  logic                done_ready,
  input  logic [2:0]          result_sel,
  output logic [31:0]         result,
  output logic [ROUNDS_W-1:0] round_cnt,
  output logic [2:0]          stage
`ifdef MIX_SEQ_ABORT_EN
  ,
  input  logic                abort
`endif
);

  // Handshakes: start is accepted on an edge with start_valid && start_ready;
  // the result is consumed on an edge with done_valid && done_ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] MUL_A [8] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam logic [31:0] ADD_B [8] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
  localparam logic [31:0] MUL_C [8] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
  localparam logic [31:0] ADD_D [8] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};

  state_t              state;
  state_t              state_nx;
  logic [31:0]         o   [8];
  logic [31:0]         mix [8];
  logic [ROUNDS_W-1:0] target;
  logic [ROUNDS_W-1:0] round_inc;
  logic                abort_hit;
  logic                last_stage;

`ifdef MIX_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign start_ready = (state == IDLE);
  assign busy        = (state == RUN);
  assign done_valid  = (state == DONE);
  assign result      = o[result_sel];
  assign round_inc   = round_cnt + 1'b1;
  // A target of zero wraps round_inc back to zero after 2^ROUNDS_W rounds.
  assign last_stage  = (stage == 3'd7) && (round_inc == target);

  // Words are updated in index order, each reading the already-updated lower words.
  always_comb begin
    for (int i = 0; i < 8; i++) mix[i] = o[i];
    for (int i = 0; i < 8; i++) begin
      case (stage)
        3'd0: mix[i] = mix[i] + 32'(i);
        3'd1: mix[i] = mix[i] + mix[3'(i + 7)];
        3'd2: mix[i] = mix[i] + mix[3'(i + 1)] - mix[3'(i + 5)];
        3'd3: mix[i] = mix[i] ^ (mix[3'(i + 3)] << 16);
        3'd4: mix[i] = mix[i] - (mix[3'(i + 2)] >> 17) + (mix[3'(i + 4)] >> 12);
        3'd5: mix[i] = mix[i] + mix[3'(i + 7)] - mix[3'(i + 6)];
        3'd6: mix[i] = mix[i] * MUL_A[i] + ADD_B[i];
        default: mix[i] = mix[i] * MUL_C[i] + ADD_D[i];
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_valid) state_nx = RUN;
      RUN: begin
        if (abort_hit)       state_nx = IDLE;
        else if (last_stage) state_nx = DONE;
      end
      DONE: if (done_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stage     <= 3'd0;
      round_cnt <= '0;
      target    <= '0;
      for (int i = 0; i < 8; i++) o[i] <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start_valid) begin
            stage     <= 3'd0;
            round_cnt <= '0;
            target    <= rounds;
            for (int i = 0; i < 8; i++) o[i] <= seed + 32'(i);
          end
        end
        RUN: begin
          // An aborted edge applies no stage so the partial state stays inspectable.
          if (!abort_hit) begin
            stage <= stage + 3'd1;
            if (stage == 3'd7) round_cnt <= round_inc;
            for (int i = 0; i < 8; i++) o[i] <= mix[i];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_round_sequencer.sv
// Directed bench for mix_round_sequencer: reset values, stage timing, full-range rounds,
// result hold under backpressure, mid-job reset and (with MIX_SEQ_ABORT_EN) abort.
module tb_mix_round_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] seed;
  logic [3:0]  rounds;
  logic        busy;
  logic        done_valid;
  logic        done_ready;
  logic [2:0]  result_sel;
  logic [31:0] result;
  logic [3:0]  round_cnt;
  logic [2:0]  stage;
`ifdef MIX_SEQ_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] m [8];
  localparam logic [31:0] KA [8] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam logic [31:0] KB [8] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
  localparam logic [31:0] KC [8] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
  localparam logic [31:0] KD [8] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};

  mix_round_sequencer #(.ROUNDS_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .seed        (seed),
    .rounds      (rounds),
    .busy        (busy),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .result_sel  (result_sel),
    .result      (result),
    .round_cnt   (round_cnt),
    .stage       (stage)
`ifdef MIX_SEQ_ABORT_EN
    ,
    .abort       (abort)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model of the mixing stages, sequential word order.
  function automatic void model_init(input logic [31:0] s);
    for (int i = 0; i < 8; i++) m[i] = s + 32'(i);
  endfunction

  function automatic void model_stage(input int k);
    for (int i = 0; i < 8; i++) begin
      case (k)
        0: m[i] = m[i] + 32'(i);
        1: m[i] = m[i] + m[(i + 7) % 8];
        2: m[i] = m[i] + m[(i + 1) % 8] - m[(i + 5) % 8];
        3: m[i] = m[i] ^ (m[(i + 3) % 8] << 16);
        4: m[i] = m[i] - (m[(i + 2) % 8] >> 17) + (m[(i + 4) % 8] >> 12);
        5: m[i] = m[i] + m[(i + 7) % 8] - m[(i + 6) % 8];
        6: m[i] = m[i] * KA[i] + KB[i];
        default: m[i] = m[i] * KC[i] + KD[i];
      endcase
    end
  endfunction

  function automatic void model_rounds(input int r);
    for (int j = 0; j < r; j++)
      for (int k = 0; k < 8; k++) model_stage(k);
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] s, input logic [3:0] r);
    seed        = s;
    rounds      = r;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    seed        = $urandom;
    rounds      = 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    start_valid = 1'b0;
    seed        = 32'd0;
    rounds      = 4'd0;
    done_ready  = 1'b0;
    result_sel  = 3'd0;
`ifdef MIX_SEQ_ABORT_EN
    abort       = 1'b0;
`endif
    #35;
    rst_n = 1'b1;
    step();
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready/busy/done = %b%b%b, expected 100", start_ready, busy, done_valid);
    end
    checks++;
    if (round_cnt !== 4'd0 || stage !== 3'd0) begin
      errors++;
      $display("FAIL reset_counters: round_cnt=%0d stage=%0d, expected 0 0", round_cnt, stage);
    end
    for (int i = 0; i < 8; i++) begin
      result_sel = 3'(i);
      #1;
      checks++;
      if (result !== 32'd0) begin
        errors++;
        $display("FAIL reset_result[%0d]: got %h, expected 0", i, result);
      end
    end
  endtask

  task automatic test_single_round();
    int n;
    done_ready = 1'b1;
    start_job(32'd0, 4'd1);
    checks++;
    if (busy !== 1'b1 || start_ready !== 1'b0 || stage !== 3'd0) begin
      errors++;
      $display("FAIL accept: busy=%b start_ready=%b stage=%0d, expected 1 0 0", busy, start_ready, stage);
    end
    step();
    n = 1;
    checks++;
    if (stage !== 3'd1) begin
      errors++;
      $display("FAIL stage0_ptr: stage=%0d, expected 1", stage);
    end
    for (int i = 0; i < 8; i++) begin
      result_sel = 3'(i);
      #1;
      checks++;
      if (result !== 32'(2 * i)) begin
        errors++;
        $display("FAIL stage0_word[%0d]: got %0d, expected %0d", i, result, 2 * i);
      end
    end
    while (done_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL r1_latency: done after %0d edges, expected 8", n);
    end
    model_init(32'd0);
    model_rounds(1);
    for (int i = 0; i < 8; i++) begin
      result_sel = 3'(i);
      #1;
      checks++;
      if (result !== m[i]) begin
        errors++;
        $display("FAIL r1_word[%0d]: got %h, expected %h", i, result, m[i]);
      end
    end
    checks++;
    if (round_cnt !== 4'd1 || stage !== 3'd0) begin
      errors++;
      $display("FAIL r1_counters: round_cnt=%0d stage=%0d, expected 1 0", round_cnt, stage);
    end
    step();
    checks++;
    if (start_ready !== 1'b1 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL r1_release: start_ready=%b done_valid=%b, expected 1 0", start_ready, done_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start_job(32'hdeadbeef, 4'd2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b, expected 1", busy);
    end
    n = 0;
    while (done_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL b2b_latency: done after %0d edges, expected 16", n);
    end
    model_init(32'hdeadbeef);
    model_rounds(2);
    for (int i = 0; i < 8; i++) begin
      result_sel = 3'(i);
      #1;
      checks++;
      if (result !== m[i]) begin
        errors++;
        $display("FAIL b2b_word[%0d]: got %h, expected %h", i, result, m[i]);
      end
    end
    step();
  endtask

  task automatic test_max_rounds();
    int busy_cycles;
    start_job(32'd0, 4'd0);
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 300) begin
      busy_cycles++;
      step();
    end
    checks++;
    if (busy_cycles !== 128 || done_valid !== 1'b1) begin
      errors++;
      $display("FAIL r16_busy: busy for %0d cycles done_valid=%b, expected 128 1", busy_cycles, done_valid);
    end
    checks++;
    if (round_cnt !== 4'd0) begin
      errors++;
      $display("FAIL r16_round_cnt: got %0d, expected 0", round_cnt);
    end
    model_init(32'd0);
    model_rounds(16);
    for (int i = 0; i < 8; i++) begin
      result_sel = 3'(i);
      #1;
      checks++;
      if (result !== m[i]) begin
        errors++;
        $display("FAIL r16_word[%0d]: got %h, expected %h", i, result, m[i]);
      end
    end
    step();
  endtask

  task automatic test_hold();
    int n;
    done_ready = 1'b0;
    start_job(32'h0badf00d, 4'd3);
    n = 0;
    while (done_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n !== 24) begin
      errors++;
      $display("FAIL hold_latency: done after %0d edges, expected 24", n);
    end
    model_init(32'h0badf00d);
    model_rounds(3);
    result_sel = 3'd5;
    for (int c = 0; c < 20; c++) begin
      start_valid = c[0];
      step();
      checks++;
      if (done_valid !== 1'b1 || start_ready !== 1'b0 || result !== m[5]) begin
        errors++;
        $display("FAIL hold_cycle%0d: done_valid=%b start_ready=%b result=%h, expected 1 0 %h",
                 c, done_valid, start_ready, result, m[5]);
      end
    end
    start_valid = 1'b0;
    done_ready  = 1'b1;
    step();
    done_ready  = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: start_ready=%b done_valid=%b, expected 1 0", start_ready, done_valid);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      result_sel = 3'(i);
      #1;
      checks++;
      if (result !== m[i]) begin
        errors++;
        $display("FAIL idle_hold_word[%0d]: got %h, expected %h", i, result, m[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    done_ready = 1'b1;
    start_job(32'h55aa55aa, 4'd5);
    for (int c = 0; c < 24; c++) begin
      step();
      checks++;
      if (done_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrun_early_done: cycle %0d done_valid=%b, expected 0", c, done_valid);
      end
    end
    checks++;
    if (round_cnt !== 4'd3 || stage !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_progress: round_cnt=%0d stage=%0d busy=%b, expected 3 0 1", round_cnt, stage, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0 ||
        round_cnt !== 4'd0 || stage !== 3'd0) begin
      errors++;
      $display("FAIL midrun_reset: ready=%b busy=%b done=%b round_cnt=%0d stage=%0d, expected 1 0 0 0 0",
               start_ready, busy, done_valid, round_cnt, stage);
    end
    for (int i = 0; i < 8; i++) begin
      result_sel = 3'(i);
      #1;
      checks++;
      if (result !== 32'd0) begin
        errors++;
        $display("FAIL midrun_reset_word[%0d]: got %h, expected 0", i, result);
      end
    end
    step();
    rst_n = 1'b1;
    step();
    start_job(32'd7, 4'd1);
    n = 0;
    while (done_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL seed7_latency: done after %0d edges, expected 8", n);
    end
    model_init(32'd7);
    model_rounds(1);
    for (int i = 0; i < 8; i++) begin
      result_sel = 3'(i);
      #1;
      checks++;
      if (result !== m[i]) begin
        errors++;
        $display("FAIL seed7_word[%0d]: got %h, expected %h", i, result, m[i]);
      end
    end
    step();
  endtask

`ifdef MIX_SEQ_ABORT_EN
  task automatic test_abort();
    start_job(32'h13579bdf, 4'd4);
    for (int c = 0; c < 10; c++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || round_cnt !== 4'd1 || stage !== 3'd2) begin
      errors++;
      $display("FAIL abort_state: ready=%b busy=%b round_cnt=%0d stage=%0d, expected 1 0 1 2",
               start_ready, busy, round_cnt, stage);
    end
    model_init(32'h13579bdf);
    model_rounds(1);
    model_stage(0);
    model_stage(1);
    for (int i = 0; i < 8; i++) begin
      result_sel = 3'(i);
      #1;
      checks++;
      if (result !== m[i]) begin
        errors++;
        $display("FAIL abort_word[%0d]: got %h, expected %h", i, result, m[i]);
      end
    end
    for (int c = 0; c < 40; c++) begin
      step();
      checks++;
      if (done_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done: cycle %0d done_valid=%b, expected 0", c, done_valid);
      end
    end
    abort = 1'b1;
    start_job(32'd0, 4'd1);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_start_same_edge: busy=%b, expected 1", busy);
    end
    for (int c = 0; c < 10; c++) step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_round();
    test_back_to_back();
    test_max_rounds();
    test_hold();
    test_reset_mid_run();
`ifdef MIX_SEQ_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
